// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : alu_arbiter (with mips_core_pkg, alu_input_ifc,            |
// |               alu_output_ifc)                                            |
// | Description : Two-requester front end for a single shared combinational  |
// |               ALU. One operation is granted per cycle (round-robin on    |
// |               contention). The ALU result is captured into a per-        |
// |               requester response slot one cycle after the grant.         |
// | Ports       : clk, rst (sync, active high)                               |
// |               reqN_valid/ready/alu_ctl/op1/op2/tag   request side, N=0,1  |
// |               rspN_valid/ready/result/branch_outcome/tag response side   |
// |               alu_req (to ALU), alu_rsp (from ALU)                       |
// |               grant_count  accepted operations since reset (wraps)       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_core_pkg;
  typedef enum logic [3:0] {
    ALUCTL_NOP  = 4'd0,
    ALUCTL_ADD  = 4'd1,
    ALUCTL_SUB  = 4'd2,
    ALUCTL_AND  = 4'd3,
    ALUCTL_OR   = 4'd4,
    ALUCTL_SLT  = 4'd5,
    ALUCTL_BEQ  = 4'd6,
    ALUCTL_BNE  = 4'd7,
    ALUCTL_MTC0 = 4'd8
  } AluCtl;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;
endpackage

interface alu_input_ifc;
  logic                                 valid;
  mips_core_pkg::AluCtl                 alu_ctl;
  logic signed [`DATA_WIDTH-1:0]        op1;
  logic signed [`DATA_WIDTH-1:0]        op2;

  modport in  (input  valid, alu_ctl, op1, op2);
  modport out (output valid, alu_ctl, op1, op2);
endinterface

interface alu_output_ifc;
  logic                                 valid;
  logic signed [`DATA_WIDTH-1:0]        result;
  mips_core_pkg::BranchOutcome          branch_outcome;

  modport in  (input  valid, result, branch_outcome);
  modport out (output valid, result, branch_outcome);
endinterface

module alu_arbiter #(
  parameter int TAG_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  mips_core_pkg::AluCtl          req0_alu_ctl,
  input  logic signed [`DATA_WIDTH-1:0] req0_op1,
  input  logic signed [`DATA_WIDTH-1:0] req0_op2,
  input  logic [TAG_WIDTH-1:0]          req0_tag,

  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  mips_core_pkg::AluCtl          req1_alu_ctl,
  input  logic signed [`DATA_WIDTH-1:0] req1_op1,
  input  logic signed [`DATA_WIDTH-1:0] req1_op2,
  input  logic [TAG_WIDTH-1:0]          req1_tag,

  output logic                          rsp0_valid,
  input  logic                          rsp0_ready,
  output logic signed [`DATA_WIDTH-1:0] rsp0_result,
  output mips_core_pkg::BranchOutcome   rsp0_branch_outcome,
  output logic [TAG_WIDTH-1:0]          rsp0_tag,

  output logic                          rsp1_valid,
  input  logic                          rsp1_ready,
  output logic signed [`DATA_WIDTH-1:0] rsp1_result,
  output mips_core_pkg::BranchOutcome   rsp1_branch_outcome,
  output logic [TAG_WIDTH-1:0]          rsp1_tag,

  alu_input_ifc.out                     alu_req,
  alu_output_ifc.in                     alu_rsp,

  output logic [31:0]                   grant_count
);
  import mips_core_pkg::*;

  // Response slots
  logic                          r_rsp0_valid;
  logic signed [`DATA_WIDTH-1:0] r_rsp0_result;
  BranchOutcome                  r_rsp0_branch_outcome;
  logic [TAG_WIDTH-1:0]          r_rsp0_tag;
  logic                          r_rsp1_valid;
  logic signed [`DATA_WIDTH-1:0] r_rsp1_result;
  BranchOutcome                  r_rsp1_branch_outcome;
  logic [TAG_WIDTH-1:0]          r_rsp1_tag;

  // Round-robin pointer: names the requester that wins a tie
  logic                          r_ptr;
  logic [31:0]                   r_grant_count;

  logic w_elig0, w_elig1;
  logic w_grant0, w_grant1;

  // A slot draining this cycle counts as free, giving 1/cycle throughput.
  // Eligibility is gated with rst so nothing is granted during reset.
  always_comb begin
    w_elig0  = !rst && req0_valid && (!r_rsp0_valid || rsp0_ready);
    w_elig1  = !rst && req1_valid && (!r_rsp1_valid || rsp1_ready);
    w_grant0 = w_elig0 && (!w_elig1 || !r_ptr);
    w_grant1 = w_elig1 && (!w_elig0 ||  r_ptr);
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  always_comb begin
    alu_req.valid   = 1'b0;
    alu_req.alu_ctl = ALUCTL_NOP;
    alu_req.op1     = '0;
    alu_req.op2     = '0;
    if (w_grant0) begin
      alu_req.valid   = 1'b1;
      alu_req.alu_ctl = req0_alu_ctl;
      alu_req.op1     = req0_op1;
      alu_req.op2     = req0_op2;
    end else if (w_grant1) begin
      alu_req.valid   = 1'b1;
      alu_req.alu_ctl = req1_alu_ctl;
      alu_req.op1     = req1_op1;
      alu_req.op2     = req1_op2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp0_valid          <= 1'b0;
      r_rsp0_result         <= '0;
      r_rsp0_branch_outcome <= NOT_TAKEN;
      r_rsp0_tag            <= '0;
      r_rsp1_valid          <= 1'b0;
      r_rsp1_result         <= '0;
      r_rsp1_branch_outcome <= NOT_TAKEN;
      r_rsp1_tag            <= '0;
      r_ptr                 <= 1'b0;
      r_grant_count         <= '0;
    end else begin
      // A new grant takes precedence over a drain on the same slot
      if (w_grant0) begin
        r_rsp0_valid          <= 1'b1;
        r_rsp0_result         <= alu_rsp.result;
        r_rsp0_branch_outcome <= alu_rsp.branch_outcome;
        r_rsp0_tag            <= req0_tag;
      end else if (rsp0_ready) begin
        r_rsp0_valid          <= 1'b0;
      end

      if (w_grant1) begin
        r_rsp1_valid          <= 1'b1;
        r_rsp1_result         <= alu_rsp.result;
        r_rsp1_branch_outcome <= alu_rsp.branch_outcome;
        r_rsp1_tag            <= req1_tag;
      end else if (rsp1_ready) begin
        r_rsp1_valid          <= 1'b0;
      end

      // Pointer moves to the requester that lost (or was absent)
      if (w_grant0) begin
        r_ptr <= 1'b1;
      end else if (w_grant1) begin
        r_ptr <= 1'b0;
      end

      if (w_grant0 || w_grant1) begin
        r_grant_count <= r_grant_count + 32'd1;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && (w_grant0 || w_grant1) && !alu_rsp.valid) begin
      $display("alu_arbiter error: alu_rsp.valid low during grant at time %0t", $time);
    end
  end
`endif

  assign rsp0_valid          = r_rsp0_valid;
  assign rsp0_result         = r_rsp0_result;
  assign rsp0_branch_outcome = r_rsp0_branch_outcome;
  assign rsp0_tag            = r_rsp0_tag;
  assign rsp1_valid          = r_rsp1_valid;
  assign rsp1_result         = r_rsp1_result;
  assign rsp1_branch_outcome = r_rsp1_branch_outcome;
  assign rsp1_tag            = r_rsp1_tag;
  assign grant_count         = r_grant_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_arbiter                                             |
// | Description : Self-checking bench for alu_arbiter. A behavioural ALU     |
// |               feeds alu_rsp; a slot/pointer/count reference model        |
// |               predicts readies, ALU request and captured responses.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_alu_arbiter;
  import mips_core_pkg::*;

  localparam int TW = 4;
  localparam int DW = `DATA_WIDTH;

  logic clk;
  logic rst;

  logic                 rq_valid [2];
  logic                 rq_ready [2];
  AluCtl                rq_ctl   [2];
  logic signed [DW-1:0] rq_op1   [2];
  logic signed [DW-1:0] rq_op2   [2];
  logic [TW-1:0]        rq_tag   [2];
  logic                 rs_valid [2];
  logic                 rs_ready [2];
  logic signed [DW-1:0] rs_result[2];
  BranchOutcome         rs_br    [2];
  logic [TW-1:0]        rs_tag   [2];
  logic [31:0]          grant_count;
  logic                 alu_valid_en;

  alu_input_ifc  alu_req_if ();
  alu_output_ifc alu_rsp_if ();

  alu_arbiter #(.TAG_WIDTH(TW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req0_valid          (rq_valid[0]),
    .req0_ready          (rq_ready[0]),
    .req0_alu_ctl        (rq_ctl[0]),
    .req0_op1            (rq_op1[0]),
    .req0_op2            (rq_op2[0]),
    .req0_tag            (rq_tag[0]),
    .req1_valid          (rq_valid[1]),
    .req1_ready          (rq_ready[1]),
    .req1_alu_ctl        (rq_ctl[1]),
    .req1_op1            (rq_op1[1]),
    .req1_op2            (rq_op2[1]),
    .req1_tag            (rq_tag[1]),
    .rsp0_valid          (rs_valid[0]),
    .rsp0_ready          (rs_ready[0]),
    .rsp0_result         (rs_result[0]),
    .rsp0_branch_outcome (rs_br[0]),
    .rsp0_tag            (rs_tag[0]),
    .rsp1_valid          (rs_valid[1]),
    .rsp1_ready          (rs_ready[1]),
    .rsp1_result         (rs_result[1]),
    .rsp1_branch_outcome (rs_br[1]),
    .rsp1_tag            (rs_tag[1]),
    .alu_req             (alu_req_if),
    .alu_rsp             (alu_rsp_if),
    .grant_count         (grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU
  function automatic logic signed [DW-1:0] alu_res(input AluCtl c,
      input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    case (c)
      ALUCTL_ADD: return a + b;
      ALUCTL_SUB: return a - b;
      ALUCTL_AND: return a & b;
      ALUCTL_OR:  return a | b;
      ALUCTL_SLT: return (a < b) ? 1 : 0;
      default:    return 0;
    endcase
  endfunction

  function automatic BranchOutcome alu_br(input AluCtl c,
      input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    if (c == ALUCTL_BEQ) return (a == b) ? TAKEN : NOT_TAKEN;
    if (c == ALUCTL_BNE) return (a != b) ? TAKEN : NOT_TAKEN;
    return NOT_TAKEN;
  endfunction

  always_comb begin
    alu_rsp_if.valid          = alu_valid_en;
    alu_rsp_if.result         = alu_res(alu_req_if.alu_ctl, alu_req_if.op1, alu_req_if.op2);
    alu_rsp_if.branch_outcome = alu_br(alu_req_if.alu_ctl, alu_req_if.op1, alu_req_if.op2);
  end

  // Reference model state
  bit                   m_valid[2];
  logic signed [DW-1:0] m_res  [2];
  BranchOutcome         m_br   [2];
  logic [TW-1:0]        m_tag  [2];
  int                   m_ptr;
  logic [31:0]          m_count;

  int checks;
  int passes;
  int obs_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_valid[n] = 0;
      m_res[n]   = '0;
      m_br[n]    = NOT_TAKEN;
      m_tag[n]   = '0;
    end
    m_ptr   = 0;
    m_count = '0;
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      rq_valid[n] = 1'b0;
      rq_ctl[n]   = ALUCTL_NOP;
      rq_op1[n]   = '0;
      rq_op2[n]   = '0;
      rq_tag[n]   = '0;
      rs_ready[n] = 1'b0;
    end
  endtask

  task automatic set_req(input int n, input AluCtl c, input int a, input int b, input int t);
    rq_valid[n] = 1'b1;
    rq_ctl[n]   = c;
    rq_op1[n]   = a;
    rq_op2[n]   = b;
    rq_tag[n]   = TW'(t);
  endtask

  // One clock cycle with the currently driven inputs: check the combinational
  // grant path, let the edge happen, then check captured state.
  task automatic cycle();
    bit el[2];
    int g;
    logic signed [DW-1:0] e_res;
    BranchOutcome e_br;
    #1;
    for (int n = 0; n < 2; n++) el[n] = rq_valid[n] && (!m_valid[n] || rs_ready[n]);
    if (el[0] && el[1]) g = m_ptr;
    else if (el[0])     g = 0;
    else if (el[1])     g = 1;
    else                g = -1;
    obs_g = rq_ready[0] ? 0 : (rq_ready[1] ? 1 : -1);
    chk("req0_ready", rq_ready[0], g == 0);
    chk("req1_ready", rq_ready[1], g == 1);
    chk("alu_req_valid", alu_req_if.valid, g >= 0);
    e_res = '0;
    e_br  = NOT_TAKEN;
    if (g >= 0) begin
      chk("alu_req_ctl", alu_req_if.alu_ctl, rq_ctl[g]);
      chk("alu_req_ops", {alu_req_if.op1, alu_req_if.op2}, {rq_op1[g], rq_op2[g]});
      e_res = alu_res(rq_ctl[g], rq_op1[g], rq_op2[g]);
      e_br  = alu_br(rq_ctl[g], rq_op1[g], rq_op2[g]);
    end else begin
      chk("alu_req_idle", {alu_req_if.alu_ctl, alu_req_if.op1, alu_req_if.op2}, {ALUCTL_NOP, 64'd0});
    end
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      if (g == n) begin
        m_valid[n] = 1;
        m_res[n]   = e_res;
        m_br[n]    = e_br;
        m_tag[n]   = rq_tag[n];
      end else if (rs_ready[n]) begin
        m_valid[n] = 0;
      end
    end
    if (g >= 0) begin
      m_ptr   = 1 - g;
      m_count = m_count + 32'd1;
    end
    @(negedge clk);
    chk("grant_count", grant_count, m_count);
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("rsp%0d_valid", n), rs_valid[n], m_valid[n]);
      if (m_valid[n]) begin
        chk($sformatf("rsp%0d_result", n), rs_result[n], m_res[n]);
        chk($sformatf("rsp%0d_branch", n), rs_br[n], m_br[n]);
        chk($sformatf("rsp%0d_tag", n), rs_tag[n], m_tag[n]);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq_valid[0] = 1'b1;
    rq_valid[1] = 1'b1;
    #1;
    chk("rst_req0_ready", rq_ready[0], 1'b0);
    chk("rst_req1_ready", rq_ready[1], 1'b0);
    chk("rst_alu_valid", alu_req_if.valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {rs_valid[0], rs_valid[1]}, 2'b00);
    chk("rst_grant_count", grant_count, 32'd0);
    chk("rst_rsp_data", {rs_result[0], rs_result[1], rs_tag[0], rs_tag[1]}, 64'd0);
    idle_inputs();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    alu_valid_en = 1'b1;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // Single op: ADD 5+7, tag 3
    set_req(0, ALUCTL_ADD, 5, 7, 3);
    cycle();
    chk("single_grant", obs_g, 0);
    chk("single_result", {rs_valid[0], rs_result[0], rs_tag[0]}, {1'b1, 32'sd12, 4'd3});
    idle_inputs();
    rs_ready[0] = 1'b1;
    cycle();

    // Contention from reset: grants 0,1,0,1
    do_reset();
    set_req(0, ALUCTL_ADD, 1, 2, 1);
    set_req(1, ALUCTL_SUB, 8, 3, 2);
    rs_ready[0] = 1'b1;
    rs_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("contend_grant%0d", i), obs_g, i % 2);
    end
    chk("contend_count", grant_count, 32'd4);

    // Backpressure on slot 0 does not block requester 1
    do_reset();
    set_req(0, ALUCTL_ADD, 1, 1, 4);
    cycle();
    set_req(0, ALUCTL_OR, 6, 9, 5);
    set_req(1, ALUCTL_SUB, 9, 4, 6);
    cycle();
    chk("bp_req0_ready", rq_ready[0], 1'b0);
    chk("bp_rsp0_stable", {rs_result[0], rs_tag[0]}, {32'sd2, 4'd4});
    chk("bp_rsp1_result", rs_result[1], 32'sd5);
    rq_valid[1] = 1'b0;
    cycle();
    chk("bp_rsp0_hold", rs_result[0], 32'sd2);

    // Drain + refill on slot 0: BEQ 2==2
    set_req(0, ALUCTL_BEQ, 2, 2, 7);
    rs_ready[0] = 1'b1;
    rs_ready[1] = 1'b1;
    cycle();
    chk("refill_grant", obs_g, 0);
    chk("refill_branch", {rs_valid[0], rs_br[0]}, {1'b1, TAKEN});

    // Reset the cycle after a grant
    idle_inputs();
    set_req(0, ALUCTL_ADD, 3, 3, 8);
    cycle();
    do_reset();
    set_req(0, ALUCTL_AND, 12, 10, 9);
    set_req(1, ALUCTL_SLT, -1, 1, 10);
    cycle();
    chk("post_rst_first_grant", obs_g, 0);

    // Grant counter wrap
    idle_inputs();
    rs_ready[0] = 1'b1;
    rs_ready[1] = 1'b1;
    cycle();
    force dut.r_grant_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_grant_count;
    m_count = 32'hFFFF_FFFF;
    set_req(1, ALUCTL_MTC0, 77, 5, 11);
    cycle();
    chk("wrap_count", grant_count, 32'd0);
    chk("mtc0_result", rs_result[1], 32'sd0);

    // ALU response not valid during a grant: still captured
    idle_inputs();
    rs_ready[0] = 1'b1;
    rs_ready[1] = 1'b1;
    alu_valid_en = 1'b0;
    set_req(0, ALUCTL_SUB, 20, 30, 12);
    cycle();
    chk("novalid_capture", rs_result[0], -32'sd10);
    alu_valid_en = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      for (int n = 0; n < 2; n++) begin
        rq_valid[n] = ($urandom_range(0, 3) != 0);
        rq_ctl[n]   = AluCtl'($urandom_range(1, 8));
        if ($urandom_range(0, 1) == 1) begin
          rq_op1[n] = $urandom_range(0, 3);
          rq_op2[n] = $urandom_range(0, 3);
        end else begin
          rq_op1[n] = $urandom;
          rq_op2[n] = $urandom;
        end
        rq_tag[n]   = TW'($urandom);
        rs_ready[n] = ($urandom_range(0, 2) != 0);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: TAG_WIDTH, default 4, width of the requester-supplied tag returned with each response.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 Port: reqN_ready  output  1  operation from requester N is accepted this cycle.
REQ-006 Port: reqN_alu_ctl  input  mips_core_pkg::AluCtl  operation code.
REQ-007 Port: reqN_op1, reqN_op2  input  `DATA_WIDTH each  signed operands.
REQ-008 Port: reqN_tag  input  TAG_WIDTH  opaque tag.
REQ-009 Port: rspN_valid  output  1  response for requester N held.
REQ-010 Port: rspN_ready  input  1  requester N consumes its response.
REQ-011 Port: rspN_result  output  `DATA_WIDTH  captured ALU result.
REQ-012 Port: rspN_branch_outcome  output  mips_core_pkg::BranchOutcome  captured branch outcome.
REQ-013 Port: rspN_tag  output  TAG_WIDTH  tag of the accepted request.
REQ-014 Port: alu_req  alu_input_ifc.out  drives the shared ALU (valid, alu_ctl, op1, op2).
REQ-015 Port: alu_rsp  alu_output_ifc.in  combinational ALU result (valid, result, branch_outcome).
REQ-016 Port: grant_count  output  32  total accepted operations since reset, wraps at 2^32.

Function
REQ-017 The block SHALL accept at most one operation per cycle; a handshake occurs on reqN_valid & reqN_ready.
REQ-018 Slot N is free when rspN_valid=0, or rspN_valid=1 and rspN_ready=1 in the same cycle.
REQ-019 Requester N is eligible when reqN_valid=1 and slot N is free.
REQ-020 Arbitration: if exactly one requester is eligible, it is granted; if both are eligible, the requester named by the priority pointer is granted.
REQ-021 The priority pointer (1 bit, reset 0) SHALL move to the non-granted requester after every grant and SHALL hold when there is no grant.
REQ-022 reqN_ready SHALL be 1 only for the granted requester, combinationally in the same cycle; at most one ready is asserted.
REQ-023 On a grant, alu_req SHALL carry valid=1 and the granted requester's alu_ctl, op1 and op2 combinationally.
REQ-024 With no grant, alu_req SHALL carry valid=0, alu_ctl=ALUCTL_NOP, op1=0, op2=0.
REQ-025 On a grant to N, the next rising edge SHALL load rspN_result, rspN_branch_outcome and rspN_tag from alu_rsp and reqN_tag, and set rspN_valid=1 (latency 1 cycle).
REQ-026 rspN_valid with rspN_ready=1 and no new grant to N SHALL clear rspN_valid on the next edge.
REQ-027 Simultaneous drain and grant on slot N SHALL leave rspN_valid=1 with the new data (back-to-back throughput 1 per cycle per port).
REQ-028 While rspN_valid=1 and rspN_ready=0, the rspN_* data outputs SHALL hold stable.
REQ-029 A held response on slot N SHALL NOT block grants to the other requester.
REQ-030 grant_count SHALL increment by 1 on each grant and wrap from 0xFFFFFFFF to 0.
REQ-031 If alu_rsp.valid=0 during a grant, the block SHALL still capture the response and SHALL issue a simulation-only $display error.
REQ-032 Pass/done reporting is the ALU's responsibility; MTC0 codes are arbitrated like any other operation and return result 0.

Reset
REQ-033 While rst=1: rsp0_valid=rsp1_valid=0, all rsp data registers=0, the priority pointer=0, grant_count=0, and req0_ready=req1_ready=0.
REQ-034 A reset asserted mid-operation SHALL discard held responses; the first edge with rst=0 starts from the reset state.
REQ-035 The block SHALL assert no alu_req.valid while rst=1.

Verification
REQ-036 Single op: req0 ADD, op1=5, op2=7, tag=3 -> req0_ready=1 the same cycle; the next cycle rsp0_valid=1, result=12, tag=3.
REQ-037 Contention: both requesters valid continuously with rsp ready=1, starting from reset -> grants alternate 0,1,0,1; grant_count=4 after 4 cycles.
REQ-038 Backpressure: rsp0_ready=0 with rsp0_valid=1 and req0 valid -> req0_ready=0 and rsp0 data stable; req1 SUB 9-4 is granted and rsp1 result=5.
REQ-039 Drain+refill: rsp0_valid, rsp0_ready=1 and req0 BEQ 2==2 in the same cycle -> req0_ready=1; the next cycle rsp0_valid=1 and branch_outcome=TAKEN.
REQ-040 Reset mid-flight: rst=1 the cycle after a grant -> rsp0_valid=0, grant_count=0, pointer=0, and the next contention grants req0 first.
REQ-041 Wrap: preload grant_count to 0xFFFFFFFF via force, then one grant -> grant_count=0.
